// File: rtl/delay_monitor.sv
`default_nettype none
// ============================================================================
// Module      : delay_monitor
// Description : Receive-side checker for the periodic sig pulse. Measures
//               pulse spacing against an expected period of N+1 clocks,
//               locks after LOCK consecutive good intervals, and flags any
//               early or missing pulse after lock as a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_monitor #(
    parameter int N     = 750,
    parameter int CBITS = 10,
    parameter int LOCK  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    output logic       flg,
    output logic       err,
    output logic       early,
    output logic       late,
    output logic [3:0] good
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [CBITS-1:0] c_N    = CBITS'(N);
    localparam logic [3:0]       c_LOCK = 4'(LOCK);

    state_t             r_state, w_state_nx;
    logic [CBITS-1:0]   r_cnt, w_cnt_nx;
    logic [3:0]         r_good, w_good_nx;
    logic               r_flg, w_flg_nx;
    logic               r_err, w_err_nx;
    logic               r_early, w_early_nx;
    logic               r_late, w_late_nx;

    // One extra bit so the increment cannot overflow when LOCK is 15
    logic [4:0]         w_good_inc;
    logic [3:0]         w_good_sat;

    assign w_good_inc = {1'b0, r_good} + 5'd1;
    assign w_good_sat = (w_good_inc >= {1'b0, c_LOCK}) ? c_LOCK : w_good_inc[3:0];

    // State and status registers; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_good  <= 4'd0;
            r_flg   <= 1'b0;
            r_err   <= 1'b0;
            r_early <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_good  <= w_good_nx;
            r_flg   <= w_flg_nx;
            r_err   <= w_err_nx;
            r_early <= w_early_nx;
            r_late  <= w_late_nx;
        end
    end

    // Next-state logic: SYNC and LOCKED share the interval rules and differ
    // only in how an early/late pulse is handled
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_good_nx  = r_good;
        w_flg_nx   = r_flg;
        w_err_nx   = r_err;
        w_early_nx = 1'b0;
        w_late_nx  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_flg_nx = 1'b0;
                if (sig) begin
                    w_cnt_nx   = '0;
                    w_good_nx  = 4'd0;
                    w_state_nx = S_SYNC;
                end
            end

            S_SYNC, S_LOCKED: begin
                if (sig) begin
                    if (r_cnt == c_N) begin
                        // Pulse landed exactly in its slot
                        w_cnt_nx  = '0;
                        w_good_nx = w_good_sat;
                        if ((r_state == S_SYNC) && (w_good_sat == c_LOCK)) begin
                            w_state_nx = S_LOCKED;
                            w_flg_nx   = 1'b1;
                        end
                    end else begin
                        w_early_nx = 1'b1;
                        if (r_state == S_SYNC) begin
                            // Early pulse becomes the new timing reference
                            w_cnt_nx  = '0;
                            w_good_nx = 4'd0;
                        end else begin
                            w_state_nx = S_FAULT;
                            w_err_nx   = 1'b1;
                            w_flg_nx   = 1'b0;
                        end
                    end
                end else if (r_cnt == c_N) begin
                    // Slot passed with no pulse
                    w_late_nx = 1'b1;
                    if (r_state == S_SYNC) begin
                        w_cnt_nx   = '0;
                        w_good_nx  = 4'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_FAULT;
                        w_err_nx   = 1'b1;
                        w_flg_nx   = 1'b0;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            S_FAULT: begin
                // Terminal until reset: counters frozen, sig ignored
                w_err_nx = 1'b1;
                w_flg_nx = 1'b0;
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign flg   = r_flg;
    assign err   = r_err;
    assign early = r_early;
    assign late  = r_late;
    assign good  = r_good;

endmodule
`default_nettype wire

// File: tb/tb_delay_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_monitor
// Description : Directed, table-driven bench for delay_monitor (N=750,
//               LOCK=4) with hand-computed expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_monitor;

    logic       clk;
    logic       rst;
    logic       sig;
    logic       flg;
    logic       err;
    logic       early;
    logic       late;
    logic [3:0] good;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         zeros;
        bit         pulse;
        logic       e_flg;
        logic       e_err;
        logic       e_early;
        logic       e_late;
        logic [3:0] e_good;
    } vec_t;

    vec_t tab_lock[5];
    vec_t tab_sync[9];

    delay_monitor #(.N(750), .CBITS(10), .LOCK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sig   (sig),
        .flg   (flg),
        .err   (err),
        .early (early),
        .late  (late),
        .good  (good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int z, input bit p, input logic f, input logic e,
                                input logic ea, input logic la, input logic [3:0] g);
        vec_t v;
        v.zeros = z; v.pulse = p; v.e_flg = f; v.e_err = e;
        v.e_early = ea; v.e_late = la; v.e_good = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic f, input logic e, input logic ea,
                           input logic la, input logic [3:0] g);
        chk({tag, "_flg"},   {3'b0, flg},   {3'b0, f});
        chk({tag, "_err"},   {3'b0, err},   {3'b0, e});
        chk({tag, "_early"}, {3'b0, early}, {3'b0, ea});
        chk({tag, "_late"},  {3'b0, late},  {3'b0, la});
        chk({tag, "_good"},  good,          g);
    endtask

    // Apply v.zeros idle samples then optionally one pulse; strobes must be
    // quiet on every cycle except the final one of the record
    task automatic run_vec(input vec_t v, input string tag);
        logic mid;
        int   last;
        mid  = 1'b0;
        last = v.pulse ? -1 : v.zeros - 1;
        for (int i = 0; i < v.zeros; i++) begin
            sig = 1'b0;
            tick();
            if (i != last) mid |= (early | late);
        end
        if (v.pulse) begin
            sig = 1'b1;
            tick();
            sig = 1'b0;
        end
        chk({tag, "_mid_strobe"}, {3'b0, mid}, 4'd0);
        chk_all(tag, v.e_flg, v.e_err, v.e_early, v.e_late, v.e_good);
    endtask

    task automatic do_reset(input logic s, input string tag);
        rst = 1'b1;
        sig = s;
        tick();
        rst = 1'b0;
        sig = 1'b0;
        chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic reach_lock(input string tag);
        for (int i = 0; i < 5; i++) run_vec(tab_lock[i], $sformatf("%s%0d", tag, i));
    endtask

    initial begin
        // Ideal generator from reset: pulse k lands on edge k*751
        tab_lock[0] = mk(750, 1, 0, 0, 0, 0, 4'd0);
        tab_lock[1] = mk(750, 1, 0, 0, 0, 0, 4'd1);
        tab_lock[2] = mk(750, 1, 0, 0, 0, 0, 4'd2);
        tab_lock[3] = mk(750, 1, 0, 0, 0, 0, 4'd3);
        tab_lock[4] = mk(750, 1, 1, 0, 0, 0, 4'd4);

        // SYNC early injection, relock, then a missing pulse in LOCKED
        tab_sync[0] = mk( 10, 1, 0, 0, 0, 0, 4'd0);
        tab_sync[1] = mk(750, 1, 0, 0, 0, 0, 4'd1);
        tab_sync[2] = mk(750, 1, 0, 0, 0, 0, 4'd2);
        tab_sync[3] = mk(300, 1, 0, 0, 1, 0, 4'd0);
        tab_sync[4] = mk(750, 1, 0, 0, 0, 0, 4'd1);
        tab_sync[5] = mk(750, 1, 0, 0, 0, 0, 4'd2);
        tab_sync[6] = mk(750, 1, 0, 0, 0, 0, 4'd3);
        tab_sync[7] = mk(750, 1, 1, 0, 0, 0, 4'd4);
        tab_sync[8] = mk(751, 0, 0, 1, 0, 1, 4'd4);

        rst = 1'b1;
        sig = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sig = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Ideal lock, then stay locked for a total of 20 periods
        reach_lock("lock");
        for (int i = 0; i < 15; i++)
            run_vec(mk(750, 1, 1, 0, 0, 0, 4'd4), $sformatf("locked%0d", i));

        // Early pulse in LOCKED, then later pulses are ignored
        run_vec(mk(749, 1, 0, 1, 1, 0, 4'd4), "lk_early");
        run_vec(mk(750, 1, 0, 1, 0, 0, 4'd4), "fault_a");
        run_vec(mk(  3, 1, 0, 1, 0, 0, 4'd4), "fault_b");

        // Reset while in FAULT with sig high on the reset edge
        do_reset(1'b1, "rst_fault");

        for (int i = 0; i < 9; i++) run_vec(tab_sync[i], $sformatf("sync%0d", i));
        run_vec(mk(750, 1, 0, 1, 0, 0, 4'd4), "late_hold");

        // Double pulse in SYNC, then a missing pulse in SYNC
        do_reset(1'b0, "rst_dp");
        run_vec(mk(  5, 1, 0, 0, 0, 0, 4'd0), "dp_enter");
        run_vec(mk(750, 1, 0, 0, 0, 0, 4'd1), "dp_good");
        run_vec(mk(  0, 1, 0, 0, 1, 0, 4'd0), "dp_second");
        run_vec(mk(751, 0, 0, 0, 0, 1, 4'd0), "sync_late");
        run_vec(mk(  1, 0, 0, 0, 0, 0, 4'd0), "late_clear");
        run_vec(mk( 20, 1, 0, 0, 0, 0, 4'd0), "resync");
        run_vec(mk(750, 1, 0, 0, 0, 0, 4'd1), "resync_good");

        // Reset while LOCKED with sig high on the reset edge
        do_reset(1'b0, "rst_pre");
        reach_lock("relock");
        do_reset(1'b1, "rst_locked");
        run_vec(mk(750, 1, 0, 0, 0, 0, 4'd0), "post_rst_enter");
        run_vec(mk(750, 1, 0, 0, 0, 0, 4'd1), "post_rst_good");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
